flop_array_wrport: RTL and testbench

- Write-side companion to the flop-array read mux.
- Accepts write requests over a valid/ready handshake and registers them one stage.
- Decodes the address to a one-hot entry enable and updates a DEPTH x WIDTH flop array under a per-bit mask.
- Exposes the whole array as an unpacked output feeding the glitch-free N:1 read muxes.
- Array flops carry no reset. A post-reset init FSM sweeps INIT_VAL into every entry before the port opens.

---
 rtl/flop_array_pkg.sv | 26 ++
 rtl/flop_array_entry.sv | 17 +
 rtl/flop_array_wrport.sv | 117 +++++++++++
 tb/tb_flop_array_wrport.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/flop_array_pkg.sv
// Shared types and helpers for the flop-array write port and read-side checks.
package flop_array_pkg;

  typedef enum logic {
    FA_INIT = 1'b0,
    FA_IDLE = 1'b1
  } fa_state_t;

  // Widest array the decode helper supports; callers size-cast the result down.
  localparam int unsigned FA_MAX_DEPTH = 1024;

  // One-hot decode of an entry address; all-zero when the address is out of range.
  function automatic logic [FA_MAX_DEPTH-1:0] fa_adr_decode(input logic [31:0] adr,
                                                            input int unsigned depth);
    logic [FA_MAX_DEPTH-1:0] oh;
    oh = '0;
    if (adr < depth) oh = {{(FA_MAX_DEPTH-1){1'b0}}, 1'b1} << adr;
    return oh;
  endfunction

  function automatic logic fa_adr_in_range(input logic [31:0] adr,
                                           input int unsigned depth);
    return adr < depth;
  endfunction

endpackage

// File: rtl/flop_array_entry.sv
// One WIDTH-bit array row with enable and per-bit write mask. No reset.
module flop_array_entry #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] msk,
  output logic [WIDTH-1:0] q
);

  // Masked read-modify-write of the row on enable.
  always_ff @(posedge clk) begin
    if (en) q <= (q & ~msk) | (din & msk);
  end

endmodule

// File: rtl/flop_array_wrport.sv
// Write port for the flop array: valid/ready intake, one register stage,
// one-hot row enable, masked row update and a post-reset init sweep.
module flop_array_wrport
  import flop_array_pkg::*;
#(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     DEPTH    = 32,
  parameter int unsigned     BITDEP   = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  input  logic              wr_vld,
  output logic              wr_rdy,
  input  logic [BITDEP-1:0] wr_adr,
  input  logic [WIDTH-1:0]  wr_din,
  input  logic [WIDTH-1:0]  wr_msk,
  output logic              wr_err,
  output logic              init_done,
  output logic [DEPTH-1:0]  wr_oh,
  output logic [WIDTH-1:0]  mem [0:DEPTH-1]
);

  fa_state_t         state;
  logic [BITDEP-1:0] cnt;
  logic              s1_vld;
  logic [WIDTH-1:0]  s1_din;
  logic [WIDTH-1:0]  s1_msk;
  logic              accept;
  logic [DEPTH-1:0]  adr_oh;
  logic              adr_ok;

  assign accept = wr_vld & wr_rdy;

  // Decode the incoming address; the one-hot is registered at the accept edge.
  always_comb begin
    adr_oh = DEPTH'(fa_adr_decode(32'(wr_adr), DEPTH));
    adr_ok = fa_adr_in_range(32'(wr_adr), DEPTH);
  end

  // Init/idle FSM; wr_rdy and init_done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FA_INIT;
      cnt       <= '0;
      wr_rdy    <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        FA_INIT: begin
          if (cnt == BITDEP'(DEPTH - 1)) begin
            state     <= FA_IDLE;
            cnt       <= '0;
            wr_rdy    <= 1'b1;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FA_IDLE: begin
          if (init_req) begin
            state     <= FA_INIT;
            wr_rdy    <= 1'b0;
            init_done <= 1'b0;
          end
        end
        default: state <= FA_INIT;
      endcase
    end
  end

  // Stage-1 control: valid, row one-hot and out-of-range flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      wr_oh  <= '0;
      wr_err <= 1'b0;
    end else begin
      s1_vld <= accept;
      wr_oh  <= accept ? adr_oh : '0;
      wr_err <= accept & ~adr_ok;
    end
  end

  // Stage-1 payload; no reset needed since s1_vld qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_din <= wr_din;
      s1_msk <= wr_msk;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    logic             hit;
    logic             en;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] m;

    // Sweep wins over a landing write to the same row so the init value sticks.
    always_comb begin
      hit = (state == FA_INIT) && (cnt == BITDEP'(i));
      en  = hit | (s1_vld & wr_oh[i]);
      d   = hit ? INIT_VAL : s1_din;
      m   = hit ? '1 : s1_msk;
    end

    flop_array_entry #(.WIDTH(WIDTH)) u_row (
      .clk (clk),
      .en  (en),
      .din (d),
      .msk (m),
      .q   (mem[i])
    );
  end

endmodule

// File: tb/tb_flop_array_wrport.sv
// Self-checking bench: DEPTH=32 and DEPTH=24 instances against a transaction model.
module tb_flop_array_wrport;

  localparam int unsigned DA = 32;
  localparam int unsigned DB = 24;
  localparam logic [31:0] IA = 32'hA5A5_A5A5;
  localparam logic [31:0] IB = 32'h5A5A_0F0F;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic        init_req [2];
  logic        vld [2];
  logic [4:0]  adr [2];
  logic [31:0] din [2];
  logic [31:0] msk [2];
  logic        rdy [2];
  logic        err [2];
  logic        done [2];
  logic [31:0] oh_a;
  logic [23:0] oh_b;
  logic [31:0] mem_a [0:DA-1];
  logic [31:0] mem_b [0:DB-1];

  always #5 clk = ~clk;

  flop_array_wrport #(.WIDTH(32), .DEPTH(DA), .INIT_VAL(IA)) u_a (
    .clk(clk), .rst_n(rst_n), .init_req(init_req[0]), .wr_vld(vld[0]), .wr_rdy(rdy[0]),
    .wr_adr(adr[0]), .wr_din(din[0]), .wr_msk(msk[0]), .wr_err(err[0]),
    .init_done(done[0]), .wr_oh(oh_a), .mem(mem_a));

  flop_array_wrport #(.WIDTH(32), .DEPTH(DB), .INIT_VAL(IB)) u_b (
    .clk(clk), .rst_n(rst_n), .init_req(init_req[1]), .wr_vld(vld[1]), .wr_rdy(rdy[1]),
    .wr_adr(adr[1]), .wr_din(din[1]), .wr_msk(msk[1]), .wr_err(err[1]),
    .init_done(done[1]), .wr_oh(oh_b), .mem(mem_b));

  // Reference model: array contents, sweep cycles remaining, one pending write.
  int unsigned depth [2];
  logic [31:0] initv [2];
  logic [31:0] ref_mem [2][32];
  bit          m_rdy [2];
  int unsigned m_sweep [2];
  bit          p_vld [2];
  int unsigned p_adr [2];
  logic [31:0] p_din [2];
  logic [31:0] p_msk [2];

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int k);
    bit acc;
    acc = vld[k] && m_rdy[k];
    if (p_vld[k] && p_adr[k] < depth[k])
      ref_mem[k][p_adr[k]] = (ref_mem[k][p_adr[k]] & ~p_msk[k]) | (p_din[k] & p_msk[k]);
    if (m_sweep[k] > 0) begin
      ref_mem[k][depth[k] - m_sweep[k]] = initv[k];
      m_sweep[k]--;
      if (m_sweep[k] == 0) m_rdy[k] = 1'b1;
    end else if (m_rdy[k] && init_req[k]) begin
      m_rdy[k]   = 1'b0;
      m_sweep[k] = depth[k];
    end
    p_vld[k] = acc;
    p_adr[k] = int'(adr[k]);
    p_din[k] = din[k];
    p_msk[k] = msk[k];
  endtask

  task automatic check_all();
    logic [31:0] ea;
    logic [23:0] eb;
    ea = (p_vld[0] && p_adr[0] < DA) ? (32'h1 << p_adr[0]) : '0;
    eb = (p_vld[1] && p_adr[1] < DB) ? (24'h1 << p_adr[1]) : '0;
    chk("rdyA", rdy[0], m_rdy[0]);
    chk("doneA", done[0], m_rdy[0]);
    chk("ohA", oh_a, ea);
    chk("errA", err[0], p_vld[0] && p_adr[0] >= DA);
    chk("rdyB", rdy[1], m_rdy[1]);
    chk("doneB", done[1], m_rdy[1]);
    chk("ohB", oh_b, eb);
    chk("errB", err[1], p_vld[1] && p_adr[1] >= DB);
    for (int i = 0; i < DA; i++)
      if (!$isunknown(ref_mem[0][i])) chk($sformatf("memA[%0d]", i), mem_a[i], ref_mem[0][i]);
    for (int i = 0; i < DB; i++)
      if (!$isunknown(ref_mem[1][i])) chk($sformatf("memB[%0d]", i), mem_b[i], ref_mem[1][i]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rdyA", rdy[0], 1'b0);
    chk("rst_doneA", done[0], 1'b0);
    chk("rst_ohA", oh_a, 32'h0);
    chk("rst_errA", err[0], 1'b0);
    chk("rst_rdyB", rdy[1], 1'b0);
    chk("rst_doneB", done[1], 1'b0);
    chk("rst_ohB", oh_b, 24'h0);
    chk("rst_errB", err[1], 1'b0);
    for (int k = 0; k < 2; k++) begin
      m_rdy[k]   = 1'b0;
      m_sweep[k] = depth[k];
      p_vld[k]   = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    depth[0] = DA;
    depth[1] = DB;
    initv[0] = IA;
    initv[1] = IB;
    for (int k = 0; k < 2; k++) begin
      init_req[k] = 1'b0;
      vld[k] = 1'b0;
      adr[k] = '0;
      din[k] = '0;
      msk[k] = '0;
      p_vld[k] = 1'b0;
      p_adr[k] = 0;
      p_din[k] = '0;
      p_msk[k] = '0;
      for (int i = 0; i < 32; i++) ref_mem[k][i] = 'x;
    end

    // Reset release and init sweep: ready exactly DEPTH edges after release.
    do_reset();
    repeat (DA - 1) cyc();
    chk("doneA_at_31", done[0], 1'b0);
    cyc();
    chk("doneA_at_32", done[0], 1'b1);
    for (int i = 0; i < DA; i++) chk($sformatf("initA[%0d]", i), mem_a[i], IA);

    // Single full-mask write to entry 5.
    vld[0] = 1'b1; adr[0] = 5'd5; din[0] = 32'h1234_5678; msk[0] = '1;
    cyc();
    chk("wr5_oh", oh_a, 32'h0000_0020);
    vld[0] = 1'b0;
    cyc();
    chk("wr5_mem", mem_a[5], 32'h1234_5678);

    // Back-to-back masked writes to entry 3.
    vld[0] = 1'b1; adr[0] = 5'd3; din[0] = 32'hFFFF_0000; msk[0] = '1;
    cyc();
    din[0] = 32'h0000_FFFF; msk[0] = 32'h0000_FFFF;
    cyc();
    chk("b2b_rdy", rdy[0], 1'b1);
    vld[0] = 1'b0;
    cyc();
    chk("b2b_mem3", mem_a[3], 32'hFFFF_FFFF);

    // Out-of-range and boundary addresses on the DEPTH=24 instance.
    vld[1] = 1'b1; adr[1] = 5'd30; din[1] = 32'hDEAD_BEEF; msk[1] = '1;
    cyc();
    chk("oor30_err", err[1], 1'b1);
    chk("oor30_oh", oh_b, 24'h0);
    adr[1] = 5'd24;
    cyc();
    chk("oor24_err", err[1], 1'b1);
    adr[1] = 5'd23;
    cyc();
    chk("in23_err", err[1], 1'b0);
    chk("in23_oh", oh_b, 24'h80_0000);
    vld[1] = 1'b0;
    cyc();
    chk("oor_err_clr", err[1], 1'b0);
    chk("in23_mem", mem_b[23], 32'hDEAD_BEEF);

    // init_req with a simultaneous write; requests held during the sweep are refused.
    init_req[0] = 1'b1; vld[0] = 1'b1; adr[0] = 5'd7; din[0] = 32'h1; msk[0] = '1;
    cyc();
    chk("ireq_rdy_drop", rdy[0], 1'b0);
    init_req[0] = 1'b0;
    cyc();
    chk("ireq_mem7", mem_a[7], 32'h1);
    repeat (19) cyc();
    vld[0] = 1'b0;
    repeat (12) cyc();
    chk("ireq_done", done[0], 1'b1);
    chk("ireq_mem7_restored", mem_a[7], IA);

    // Reset during an in-flight write, then again at sweep count 10.
    vld[0] = 1'b1; adr[0] = 5'd12; din[0] = 32'hCAFE_F00D; msk[0] = '1;
    cyc();
    vld[0] = 1'b0;
    do_reset();
    repeat (10) cyc();
    do_reset();
    repeat (DA) cyc();
    chk("rst_sweep_done", done[0], 1'b1);

    // Randomized traffic, occasional re-init.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        vld[k]      = ($urandom_range(0, 9) < 7);
        adr[k]      = 5'($urandom_range(0, 31));
        din[k]      = $urandom;
        msk[k]      = $urandom;
        init_req[k] = ($urandom_range(0, 59) == 0);
      end
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0;
      init_req[k] = 1'b0;
    end
    repeat (DA + 2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
